// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one zero-latency RAM port between Channels requesters using a
// valid/ready handshake. Open arbitration is round-robin (Mode 0) or fixed
// priority with the lowest index winning (Mode 1). A transfer carrying ReqLock
// keeps the port reserved for its channel until that channel makes a transfer
// without ReqLock, or until it has been idle for LockTimeout cycles.
//
// Ports
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   ReqValid/Write/Lock  per-channel request, write flag, keep-ownership flag
//   ReqAddr, ReqData  per-channel address/write data, channel i at slice i
//   ReqReady          one-hot combinational grant
//   RspValid, RspData registered read response, one cycle after the transfer
//   LockErr           one-cycle pulse when a lock is forcibly released
//   RAMAddr, RAMDataIn, RAMWriteControl, RAMOut   RAM port
module ram_port_arbiter #(
    parameter int dataW       = 32,
    parameter int RAMAddrSize = 16,
    parameter int Channels    = 3,
    parameter int Mode        = 0,
    parameter int LockTimeout = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [Channels-1:0]             ReqValid,
    input  logic [Channels-1:0]             ReqWrite,
    input  logic [Channels-1:0]             ReqLock,
    input  logic [Channels*RAMAddrSize-1:0] ReqAddr,
    input  logic [Channels*dataW-1:0]       ReqData,
    output logic [Channels-1:0]             ReqReady,
    output logic [Channels-1:0]             RspValid,
    output logic [dataW-1:0]                RspData,
    output logic                            LockErr,
    output logic [RAMAddrSize-1:0]          RAMAddr,
    output logic [dataW-1:0]                RAMDataIn,
    output logic                            RAMWriteControl,
    input  logic [dataW-1:0]                RAMOut
);

    localparam int IW = (Channels > 1) ? $clog2(Channels) : 1;
    localparam int CW = $clog2(LockTimeout + 1);
    localparam logic [IW-1:0] LAST_RST = IW'(Channels - 1);
    localparam logic [CW-1:0] IDLE_MAX = CW'(LockTimeout - 1);

    typedef enum logic [0:0] {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e                state_q,     state_d;
    logic [IW-1:0]         last_gnt_q,  last_gnt_d;
    logic [IW-1:0]         owner_q,     owner_d;
    logic [CW-1:0]         idle_cnt_q,  idle_cnt_d;
    logic [Channels-1:0]   rsp_valid_q, rsp_valid_d;
    logic [dataW-1:0]      rsp_data_q,  rsp_data_d;
    logic                  lock_err_q,  lock_err_d;

    logic [Channels-1:0]   mask_hi_s;
    logic [IW-1:0]         open_idx_s;
    logic                  gnt_vld_s;
    logic [IW-1:0]         gnt_idx_s;
    logic                  gnt_lock_s;
    logic                  gnt_write_s;

    // Index of the lowest set bit; 0 when none is set (callers check for that).
    function automatic logic [IW-1:0] lowest_idx(input logic [Channels-1:0] v);
        logic [IW-1:0] idx;
        idx = {IW{1'b0}};
        for (int i = Channels - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IW'(i);
            end
        end
        return idx;
    endfunction

    // Open-state winner: round-robin looks above LastGnt first, then wraps.
    always_comb begin
        for (int i = 0; i < Channels; i++) begin
            mask_hi_s[i] = ReqValid[i] && (IW'(i) > last_gnt_q);
        end
        if (Mode == 0) begin
            open_idx_s = (|mask_hi_s) ? lowest_idx(mask_hi_s) : lowest_idx(ReqValid);
        end else begin
            open_idx_s = lowest_idx(ReqValid);
        end
    end

    // Grant selection; a locked port only ever serves its owner.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = {IW{1'b0}};
        case (state_q)
            ST_OPEN: begin
                gnt_vld_s = |ReqValid;
                gnt_idx_s = open_idx_s;
            end
            ST_LOCKED: begin
                gnt_vld_s = ReqValid[owner_q];
                gnt_idx_s = owner_q;
            end
            default: begin
                gnt_vld_s = 1'b0;
                gnt_idx_s = {IW{1'b0}};
            end
        endcase
    end

    // One-hot ready and the RAM-side mux, all zero when nothing is granted.
    always_comb begin
        for (int i = 0; i < Channels; i++) begin
            ReqReady[i] = gnt_vld_s && (gnt_idx_s == IW'(i));
        end
        gnt_lock_s  = ReqLock[gnt_idx_s];
        gnt_write_s = ReqWrite[gnt_idx_s];
        if (gnt_vld_s) begin
            RAMAddr         = ReqAddr[int'(gnt_idx_s) * RAMAddrSize +: RAMAddrSize];
            RAMDataIn       = ReqData[int'(gnt_idx_s) * dataW +: dataW];
            RAMWriteControl = gnt_write_s;
        end else begin
            RAMAddr         = {RAMAddrSize{1'b0}};
            RAMDataIn       = {dataW{1'b0}};
            RAMWriteControl = 1'b0;
        end
    end

    // Next-state: response capture, round-robin pointer, lock ownership/timeout.
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        owner_d     = owner_q;
        idle_cnt_d  = idle_cnt_q;
        rsp_valid_d = {Channels{1'b0}};
        rsp_data_d  = rsp_data_q;
        lock_err_d  = 1'b0;

        if (gnt_vld_s) begin
            last_gnt_d = gnt_idx_s;
            if (!gnt_write_s) begin
                rsp_valid_d = ReqReady;
                rsp_data_d  = RAMOut;
            end else begin
                rsp_valid_d = {Channels{1'b0}};
                rsp_data_d  = rsp_data_q;
            end
        end else begin
            last_gnt_d = last_gnt_q;
        end

        case (state_q)
            ST_OPEN: begin
                if (gnt_vld_s && gnt_lock_s) begin
                    state_d    = ST_LOCKED;
                    owner_d    = gnt_idx_s;
                    idle_cnt_d = {CW{1'b0}};
                end else begin
                    state_d    = ST_OPEN;
                end
            end
            ST_LOCKED: begin
                // An owner transfer always wins over an expiring idle count.
                if (gnt_vld_s) begin
                    idle_cnt_d = {CW{1'b0}};
                    state_d    = gnt_lock_s ? ST_LOCKED : ST_OPEN;
                end else if (idle_cnt_q >= IDLE_MAX) begin
                    idle_cnt_d = {CW{1'b0}};
                    state_d    = ST_OPEN;
                    lock_err_d = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d    = ST_OPEN;
                idle_cnt_d = {CW{1'b0}};
            end
        endcase
    end

    // State and response registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_OPEN;
            last_gnt_q  <= LAST_RST;
            owner_q     <= {IW{1'b0}};
            idle_cnt_q  <= {CW{1'b0}};
            rsp_valid_q <= {Channels{1'b0}};
            rsp_data_q  <= {dataW{1'b0}};
            lock_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            owner_q     <= owner_d;
            idle_cnt_q  <= idle_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            lock_err_q  <= lock_err_d;
        end
    end

    assign RspValid = rsp_valid_q;
    assign RspData  = rsp_data_q;
    assign LockErr  = lock_err_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter. Instance a is round-robin, instance b is
// fixed priority; both see the same requests and each has its own RAM whose
// unwritten words read as {16'hC0DE, address}. LockTimeout is 4 in both.
module tb_ram_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int N  = 3;
    localparam int LT = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid, req_write, req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;

    logic [N-1:0]  a_ready, a_rsp_valid, b_ready, b_rsp_valid;
    logic [DW-1:0] a_rsp_data, a_ram_din, a_ram_out, b_rsp_data, b_ram_din, b_ram_out;
    logic [AW-1:0] a_ram_addr, b_ram_addr;
    logic          a_lock_err, a_ram_we, b_lock_err, b_ram_we;

    logic [DW-1:0] mem_a [0:65535];
    logic [DW-1:0] mem_b [0:65535];

    int errors = 0;
    int checks = 0;

    ram_port_arbiter #(.dataW(DW), .RAMAddrSize(AW), .Channels(N), .Mode(0), .LockTimeout(LT)) dut_a (
        .clock(clock), .reset(reset),
        .ReqValid(req_valid), .ReqWrite(req_write), .ReqLock(req_lock),
        .ReqAddr(req_addr), .ReqData(req_data), .ReqReady(a_ready),
        .RspValid(a_rsp_valid), .RspData(a_rsp_data), .LockErr(a_lock_err),
        .RAMAddr(a_ram_addr), .RAMDataIn(a_ram_din), .RAMWriteControl(a_ram_we),
        .RAMOut(a_ram_out)
    );

    ram_port_arbiter #(.dataW(DW), .RAMAddrSize(AW), .Channels(N), .Mode(1), .LockTimeout(LT)) dut_b (
        .clock(clock), .reset(reset),
        .ReqValid(req_valid), .ReqWrite(req_write), .ReqLock(req_lock),
        .ReqAddr(req_addr), .ReqData(req_data), .ReqReady(b_ready),
        .RspValid(b_rsp_valid), .RspData(b_rsp_data), .LockErr(b_lock_err),
        .RAMAddr(b_ram_addr), .RAMDataIn(b_ram_din), .RAMWriteControl(b_ram_we),
        .RAMOut(b_ram_out)
    );

    always #5 clock = ~clock;

    assign a_ram_out = mem_a[a_ram_addr];
    assign b_ram_out = mem_b[b_ram_addr];

    // RAM models: reset reloads the default pattern, otherwise store writes.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 65536; i++) begin
                mem_a[i] <= {16'hC0DE, 16'(i)};
                mem_b[i] <= {16'hC0DE, 16'(i)};
            end
        end else begin
            if (a_ram_we) mem_a[a_ram_addr] <= a_ram_din;
            if (b_ram_we) mem_b[b_ram_addr] <= b_ram_din;
        end
    end

    task automatic set_ch(input int ch, input logic v, input logic w, input logic l,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[ch]          = v;
        req_write[ch]          = w;
        req_lock[ch]           = l;
        req_addr[ch*AW +: AW]  = a;
        req_data[ch*DW +: DW]  = d;
    endtask

    task automatic clear_all();
        req_valid = 3'b000;
        req_write = 3'b000;
        req_lock  = 3'b000;
        req_addr  = {(N*AW){1'b0}};
        req_data  = {(N*DW){1'b0}};
    endtask

    task automatic test_reset();
        clear_all();
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (a_rsp_valid !== 3'b000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 000", a_rsp_valid); end
        checks++; if (a_rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 00000000", a_rsp_data); end
        checks++; if (a_lock_err !== 1'b0 || b_lock_err !== 1'b0) begin errors++; $display("FAIL reset_lock_err: got %b/%b expected 0/0", a_lock_err, b_lock_err); end
        checks++; if (a_ready !== 3'b000 || a_ram_we !== 1'b0 || a_ram_addr !== 16'h0 || a_ram_din !== 32'h0) begin
            errors++; $display("FAIL reset_ram_side: got rdy=%b we=%b addr=%h din=%h expected all zero", a_ready, a_ram_we, a_ram_addr, a_ram_din); end
        reset = 1'b0;
    endtask

    // All three channels read continuously: a rotates 0,1,2; b always serves 0.
    task automatic test_round_robin();
        logic [2:0]  exp_g;
        logic [15:0] exp_a;
        @(negedge clock);
        set_ch(0, 1'b1, 1'b0, 1'b0, 16'h0010, 32'h0);
        set_ch(1, 1'b1, 1'b0, 1'b0, 16'h0020, 32'h0);
        set_ch(2, 1'b1, 1'b0, 1'b0, 16'h0030, 32'h0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                @(negedge clock);
                exp_g = 3'b001 << ((k - 1) % 3);
                exp_a = 16'(16 * ((k - 1) % 3 + 1));
                checks++; if (a_rsp_valid !== exp_g || a_rsp_data !== {16'hC0DE, exp_a}) begin
                    errors++; $display("FAIL rr_rsp k=%0d: got %b/%h expected %b/%h", k, a_rsp_valid, a_rsp_data, exp_g, {16'hC0DE, exp_a}); end
            end
            #1;
            exp_g = 3'b001 << (k % 3);
            exp_a = 16'(16 * (k % 3 + 1));
            checks++; if (a_ready !== exp_g || a_ram_addr !== exp_a) begin
                errors++; $display("FAIL rr_grant k=%0d: got %b/%h expected %b/%h", k, a_ready, a_ram_addr, exp_g, exp_a); end
            checks++; if (b_ready !== 3'b001) begin errors++; $display("FAIL fp_all_grant k=%0d: got %b expected 001", k, b_ready); end
        end
        @(negedge clock);
        checks++; if (a_rsp_valid !== 3'b100 || a_rsp_data !== 32'hC0DE_0030) begin
            errors++; $display("FAIL rr_rsp_last: got %b/%h expected 100/c0de0030", a_rsp_valid, a_rsp_data); end
        clear_all();
        #1;
        checks++; if (a_ready !== 3'b000 || a_ram_we !== 1'b0 || a_ram_addr !== 16'h0) begin
            errors++; $display("FAIL idle_ram_side: got %b/%b/%h expected 000/0/0000", a_ready, a_ram_we, a_ram_addr); end
    endtask

    // Channels 0 and 2 read; b starves 2 until 0 drops, a alternates.
    task automatic test_fixed_priority();
        @(negedge clock);
        set_ch(0, 1'b1, 1'b0, 1'b0, 16'h0010, 32'h0);
        set_ch(2, 1'b1, 1'b0, 1'b0, 16'h0030, 32'h0);
        #1;
        checks++; if (b_ready !== 3'b001 || a_ready !== 3'b001) begin errors++; $display("FAIL fp_c1: got b=%b a=%b expected 001/001", b_ready, a_ready); end
        @(negedge clock);
        checks++; if (b_rsp_valid !== 3'b001 || b_rsp_data !== 32'hC0DE_0010) begin
            errors++; $display("FAIL fp_rsp0: got %b/%h expected 001/c0de0010", b_rsp_valid, b_rsp_data); end
        #1;
        checks++; if (b_ready !== 3'b001 || a_ready !== 3'b100) begin errors++; $display("FAIL fp_c2: got b=%b a=%b expected 001/100", b_ready, a_ready); end
        @(negedge clock);
        #1;
        checks++; if (b_ready !== 3'b001 || a_ready !== 3'b001) begin errors++; $display("FAIL fp_c3: got b=%b a=%b expected 001/001", b_ready, a_ready); end
        @(negedge clock);
        set_ch(0, 1'b0, 1'b0, 1'b0, 16'h0010, 32'h0);
        #1;
        checks++; if (b_ready !== 3'b100 || a_ready !== 3'b100) begin errors++; $display("FAIL fp_drop0: got b=%b a=%b expected 100/100", b_ready, a_ready); end
        @(negedge clock);
        checks++; if (b_rsp_valid !== 3'b100 || b_rsp_data !== 32'hC0DE_0030 || a_rsp_valid !== 3'b100 || a_rsp_data !== 32'hC0DE_0030) begin
            errors++; $display("FAIL fp_rsp2: got b=%b/%h a=%b/%h expected 100/c0de0030", b_rsp_valid, b_rsp_data, a_rsp_valid, a_rsp_data); end
        clear_all();
    endtask

    // Locked write then read on channel 1 while 0 and 2 wait.
    task automatic test_lock();
        @(negedge clock);
        set_ch(1, 1'b1, 1'b1, 1'b1, 16'h0040, 32'hDEAD_BEEF);
        #1;
        checks++; if (a_ready !== 3'b010 || a_ram_we !== 1'b1 || a_ram_addr !== 16'h0040 || a_ram_din !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL lock_write: got %b/%b/%h/%h expected 010/1/0040/deadbeef", a_ready, a_ram_we, a_ram_addr, a_ram_din); end
        @(negedge clock);
        set_ch(1, 1'b0, 1'b0, 1'b0, 16'h0040, 32'h0);
        set_ch(0, 1'b1, 1'b0, 1'b0, 16'h0010, 32'h0);
        set_ch(2, 1'b1, 1'b0, 1'b0, 16'h0030, 32'h0);
        checks++; if (a_rsp_valid !== 3'b000 || a_rsp_data !== 32'hC0DE_0030) begin
            errors++; $display("FAIL lock_write_norsp: got %b/%h expected 000/c0de0030", a_rsp_valid, a_rsp_data); end
        #1;
        checks++; if (a_ready !== 3'b000 || b_ready !== 3'b000 || a_ram_we !== 1'b0 || a_ram_addr !== 16'h0) begin
            errors++; $display("FAIL lock_blocks_others: got a=%b b=%b we=%b addr=%h expected 000/000/0/0000", a_ready, b_ready, a_ram_we, a_ram_addr); end
        @(negedge clock);
        set_ch(1, 1'b1, 1'b0, 1'b0, 16'h0040, 32'h0);
        #1;
        checks++; if (a_ready !== 3'b010 || a_ram_addr !== 16'h0040 || a_ram_we !== 1'b0) begin
            errors++; $display("FAIL lock_read: got %b/%h/%b expected 010/0040/0", a_ready, a_ram_addr, a_ram_we); end
        @(negedge clock);
        set_ch(1, 1'b0, 1'b0, 1'b0, 16'h0040, 32'h0);
        checks++; if (a_rsp_valid !== 3'b010 || a_rsp_data !== 32'hDEAD_BEEF || a_lock_err !== 1'b0) begin
            errors++; $display("FAIL lock_read_rsp: got %b/%h/%b expected 010/deadbeef/0", a_rsp_valid, a_rsp_data, a_lock_err); end
        #1;
        checks++; if (a_ready !== 3'b100 || b_ready !== 3'b001) begin errors++; $display("FAIL unlock_next: got a=%b b=%b expected 100/001", a_ready, b_ready); end
        @(negedge clock);
        checks++; if (a_rsp_valid !== 3'b100 || a_rsp_data !== 32'hC0DE_0030) begin
            errors++; $display("FAIL unlock_rsp: got %b/%h expected 100/c0de0030", a_rsp_valid, a_rsp_data); end
        clear_all();
    endtask

    // Channel 0 locks and goes quiet; release after 4 idle edges, channel 1 next.
    task automatic test_timeout();
        @(negedge clock);
        set_ch(0, 1'b1, 1'b0, 1'b1, 16'h0010, 32'h0);
        set_ch(1, 1'b1, 1'b0, 1'b0, 16'h0020, 32'h0);
        #1;
        checks++; if (a_ready !== 3'b001) begin errors++; $display("FAIL to_lock: got %b expected 001", a_ready); end
        @(negedge clock);
        set_ch(0, 1'b0, 1'b0, 1'b0, 16'h0010, 32'h0);
        checks++; if (a_rsp_valid !== 3'b001 || a_rsp_data !== 32'hC0DE_0010) begin
            errors++; $display("FAIL to_lock_rsp: got %b/%h expected 001/c0de0010", a_rsp_valid, a_rsp_data); end
        for (int t = 1; t <= 4; t++) begin
            if (t > 1) @(negedge clock);
            checks++; if (a_lock_err !== 1'b0) begin errors++; $display("FAIL to_early_err t=%0d: got %b expected 0", t, a_lock_err); end
            #1;
            checks++; if (a_ready !== 3'b000) begin errors++; $display("FAIL to_blocked t=%0d: got %b expected 000", t, a_ready); end
        end
        @(negedge clock);
        checks++; if (a_lock_err !== 1'b1 || b_lock_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b/%b expected 1/1", a_lock_err, b_lock_err); end
        #1;
        checks++; if (a_ready !== 3'b010 || a_ram_addr !== 16'h0020) begin errors++; $display("FAIL to_release: got %b/%h expected 010/0020", a_ready, a_ram_addr); end
        @(negedge clock);
        clear_all();
        checks++; if (a_lock_err !== 1'b0) begin errors++; $display("FAIL to_err_once: got %b expected 0", a_lock_err); end
        checks++; if (a_rsp_valid !== 3'b010 || a_rsp_data !== 32'hC0DE_0020) begin
            errors++; $display("FAIL to_rsp1: got %b/%h expected 010/c0de0020", a_rsp_valid, a_rsp_data); end
    endtask

    // Reset while locked by channel 2 with its read response pending.
    task automatic test_reset_mid_lock();
        @(negedge clock);
        set_ch(2, 1'b1, 1'b0, 1'b1, 16'h0030, 32'h0);
        #1;
        checks++; if (a_ready !== 3'b100) begin errors++; $display("FAIL rml_lock: got %b expected 100", a_ready); end
        @(negedge clock);
        checks++; if (a_rsp_valid !== 3'b100) begin errors++; $display("FAIL rml_pending: got %b expected 100", a_rsp_valid); end
        clear_all();
        reset = 1'b1;
        #1;
        checks++; if (a_rsp_valid !== 3'b000 || a_rsp_data !== 32'h0 || a_lock_err !== 1'b0 || a_ready !== 3'b000) begin
            errors++; $display("FAIL rml_cleared: got %b/%h/%b/%b expected 000/00000000/0/000", a_rsp_valid, a_rsp_data, a_lock_err, a_ready); end
        @(negedge clock);
        reset = 1'b0;
        set_ch(0, 1'b1, 1'b0, 1'b0, 16'h0010, 32'h0);
        set_ch(1, 1'b1, 1'b0, 1'b0, 16'h0020, 32'h0);
        set_ch(2, 1'b1, 1'b0, 1'b0, 16'h0030, 32'h0);
        #1;
        checks++; if (a_ready !== 3'b001 || b_ready !== 3'b001) begin errors++; $display("FAIL rml_first: got a=%b b=%b expected 001/001", a_ready, b_ready); end
        @(negedge clock);
        clear_all();
        checks++; if (a_rsp_valid !== 3'b001 || a_rsp_data !== 32'hC0DE_0010) begin
            errors++; $display("FAIL rml_rsp: got %b/%h expected 001/c0de0010", a_rsp_valid, a_rsp_data); end
    endtask

    // Lone channel 1: write then read back the top address.
    task automatic test_single_channel();
        @(negedge clock);
        set_ch(1, 1'b1, 1'b1, 1'b0, 16'hFFFF, 32'h1234_5678);
        #1;
        checks++; if (a_ready !== 3'b010 || a_ram_we !== 1'b1 || b_ram_we !== 1'b1 || a_ram_addr !== 16'hFFFF || a_ram_din !== 32'h1234_5678) begin
            errors++; $display("FAIL sc_write: got %b/%b/%b/%h/%h expected 010/1/1/ffff/12345678", a_ready, a_ram_we, b_ram_we, a_ram_addr, a_ram_din); end
        @(negedge clock);
        set_ch(1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 32'h0);
        checks++; if (a_rsp_valid !== 3'b000) begin errors++; $display("FAIL sc_write_norsp: got %b expected 000", a_rsp_valid); end
        #1;
        checks++; if (a_ready !== 3'b010 || a_ram_we !== 1'b0 || b_ram_we !== 1'b0) begin
            errors++; $display("FAIL sc_read: got %b/%b/%b expected 010/0/0", a_ready, a_ram_we, b_ram_we); end
        @(negedge clock);
        clear_all();
        checks++; if (a_rsp_valid !== 3'b010 || a_rsp_data !== 32'h1234_5678 || b_rsp_valid !== 3'b010 || b_rsp_data !== 32'h1234_5678) begin
            errors++; $display("FAIL sc_rsp: got a=%b/%h b=%b/%h expected 010/12345678", a_rsp_valid, a_rsp_data, b_rsp_valid, b_rsp_data); end
        #1;
        checks++; if (a_ram_we !== 1'b0) begin errors++; $display("FAIL sc_we_low: got %b expected 0", a_ram_we); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_lock();
        test_timeout();
        test_reset_mid_lock();
        test_single_channel();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
